// File: rtl/clock_gen_pkg.sv
// -----------------------------------------------------------------------------
// clock_gen_pkg
// Shared constants and helpers for the programmable clock divider.
//   DEF_DIV_W  : default width of the divide-ratio path
//   MIN_DIV    : smallest ratio the divider will run at
//   clamp_div  : returns max(div, MIN_DIV); width-agnostic (32-bit in/out)
// -----------------------------------------------------------------------------
package clock_gen_pkg;

    localparam int DEF_DIV_W = 8;
    localparam int MIN_DIV   = 2;

    // Ratios 0 and 1 cannot form a high and a low phase, so they run as 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < 32'(MIN_DIV)) ? 32'(MIN_DIV) : div;
    endfunction

endpackage

// File: rtl/clock_gen_phase_ctr.sv
// -----------------------------------------------------------------------------
// clock_gen_phase_ctr
// Phase counter for clock_gen. r_cnt is the index (0..N-1) of the current
// REF_CLK cycle inside a CLK period; it sits at 0 while the divider is idle.
// Ports:
//   i_clk       : reference clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_clear     : force the count to 0 on this edge (period boundary / idle)
//   i_n         : ratio currently in effect (already clamped, >= 2)
//   o_wrap      : current cycle is the last one of the period (cnt == N-1)
//   o_high_next : cycle after this edge belongs to the high phase
// -----------------------------------------------------------------------------
module clock_gen_phase_ctr
    import clock_gen_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [DIV_W-1:0] i_n,
    output logic             o_wrap,
    output logic             o_high_next
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_next;
    logic [DIV_W-1:0] w_high_len;

    // ceil(N/2) written as N/2 + N[0] so N = 2^DIV_W-1 cannot overflow.
    assign w_high_len  = (i_n >> 1) + {{(DIV_W-1){1'b0}}, i_n[0]};
    assign w_cnt_next  = i_clear ? '0 : r_cnt + ONE;
    assign o_wrap      = (r_cnt == i_n - ONE);
    assign o_high_next = (w_cnt_next < w_high_len);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/clock_gen.sv
// -----------------------------------------------------------------------------
// clock_gen
// Programmable integer clock divider: CLK = REF_CLK / N, high for ceil(N/2)
// cycles and low for floor(N/2). The ratio is sampled only at a period start,
// and a stop request lets the current period finish, so CLK never glitches.
// Ports:
//   REF_CLK    : free-running reference clock, rising edge
//   RST_N      : asynchronous active-low reset
//   EN         : run request (1 = generate CLK, 0 = stop after this period)
//   DIV        : requested ratio N; 0 and 1 behave as 2
//   CLK        : generated clock, driven straight from a flop
//   DIV_ACTIVE : ratio of the period in progress (post-clamp)
//   RUNNING    : high while a CLK period is in progress
//   TICK       : (only with CLOCK_GEN_TICK_EN) one REF_CLK-cycle pulse that
//                coincides with each CLK rising edge
// Configuration macro: CLOCK_GEN_TICK_EN adds the TICK output.
// -----------------------------------------------------------------------------
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             REF_CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [DIV_W-1:0] DIV,
    output logic             CLK,
    output logic [DIV_W-1:0] DIV_ACTIVE,
    output logic             RUNNING
`ifdef CLOCK_GEN_TICK_EN
    ,
    output logic             TICK
`endif
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(clamp_div(32'(DEFAULT_DIV)));

    logic             r_clk;
    logic             r_running;
    logic [DIV_W-1:0] r_div_active;

    logic [DIV_W-1:0] w_n_req;
    logic             w_wrap;
    logic             w_high_next;
    logic             w_boundary;
    logic             w_start;

    assign w_n_req = DIV_W'(clamp_div(32'(DIV)));

    // A period may only begin on an edge that closes the previous one, or
    // from idle; anywhere else EN and DIV are ignored.
    assign w_boundary = !r_running || w_wrap;
    assign w_start    = w_boundary && EN;

    clock_gen_phase_ctr #(
        .DIV_W (DIV_W)
    ) u_phase_ctr (
        .i_clk       (REF_CLK),
        .i_rst_n     (RST_N),
        .i_clear     (w_boundary),
        .i_n         (r_div_active),
        .o_wrap      (w_wrap),
        .o_high_next (w_high_next)
    );

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_clk        <= 1'b0;
            r_running    <= 1'b0;
            r_div_active <= RESET_DIV;
        end else if (w_start) begin
            r_clk        <= 1'b1;
            r_running    <= 1'b1;
            r_div_active <= w_n_req;
        end else if (w_boundary) begin
            r_clk        <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_clk        <= w_high_next;
        end
    end

    assign CLK        = r_clk;
    assign RUNNING    = r_running;
    assign DIV_ACTIVE = r_div_active;

`ifdef CLOCK_GEN_TICK_EN
    logic r_tick;

    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_start;
        end
    end

    assign TICK = r_tick;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// -----------------------------------------------------------------------------
// tb_clock_gen
// Directed bench for clock_gen. Each stimulus step pushes the per-REF_CLK-cycle
// values it expects (CLK, RUNNING, DIV_ACTIVE, TICK) into a scoreboard queue;
// step() advances one REF_CLK cycle at a time and compares the DUT against the
// popped entry 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_clock_gen;

    localparam int DIV_W = 8;

    logic             REF_CLK;
    logic             RST_N;
    logic             EN;
    logic [DIV_W-1:0] DIV;
    logic             CLK;
    logic [DIV_W-1:0] DIV_ACTIVE;
    logic             RUNNING;
`ifdef CLOCK_GEN_TICK_EN
    logic             TICK;
`endif

    clock_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (2)
    ) dut (
        .REF_CLK    (REF_CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .DIV        (DIV),
        .CLK        (CLK),
        .DIV_ACTIVE (DIV_ACTIVE),
        .RUNNING    (RUNNING)
`ifdef CLOCK_GEN_TICK_EN
        ,
        .TICK       (TICK)
`endif
    );

    initial begin
        REF_CLK = 1'b0;
        forever #5 REF_CLK = ~REF_CLK;
    end

    typedef struct {
        logic       clk;
        logic       run;
        logic [7:0] div;
        logic       tick;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full period of ratio n: high for ceil(n/2) cycles, then low.
    task automatic push_period(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.clk  = (i < (n + 1) / 2);
            e.run  = 1'b1;
            e.div  = 8'(n);
            e.tick = (i == 0);
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int k, input int d);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            e.clk  = 1'b0;
            e.run  = 1'b0;
            e.div  = 8'(d);
            e.tick = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic step(input int k);
        exp_t e;
        for (int i = 0; i < k; i++) begin
            @(posedge REF_CLK);
            #1;
            tests_run++;
            assert (sb.size() != 0)
            else begin
                tests_failed++;
                $error("FAIL sb_empty: observed 0 entries expected >0");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("clk", 8'(CLK), 8'(e.clk));
                check("running", 8'(RUNNING), 8'(e.run));
                check("div_active", DIV_ACTIVE, e.div);
`ifdef CLOCK_GEN_TICK_EN
                check("tick", 8'(TICK), 8'(e.tick));
`endif
            end
        end
    endtask

    initial begin
        // Reset held with a run request present: nothing may start.
        RST_N = 1'b0;
        EN    = 1'b1;
        DIV   = 8'd5;
        push_idle(3, 2);
        step(3);

        // Even ratio; release with EN=1 so the next edge starts the period.
        DIV   = 8'd4;
        RST_N = 1'b1;
        push_period(4);
        push_period(4);
        step(8);

        // Odd ratio, sampled at the boundary edge.
        DIV = 8'd5;
        push_period(5);
        step(5);

        // Clamp: 0 and 1 run as 2.
        DIV = 8'd0;
        push_period(2);
        push_period(2);
        step(4);
        DIV = 8'd1;
        push_period(2);
        step(2);

        // Ratio change in the middle of a 6-cycle period.
        DIV = 8'd6;
        push_period(6);
        step(3);
        DIV = 8'd3;
        push_period(3);
        push_period(3);
        step(9);

        // Stop request at cnt=1 of an 8-cycle period, then idle, then restart.
        DIV = 8'd8;
        push_period(8);
        step(2);
        EN = 1'b0;
        step(6);
        push_idle(3, 8);
        step(3);
        EN  = 1'b1;
        DIV = 8'd4;
        push_period(4);
        step(4);

        check("sb_drained", 8'(sb.size()), 8'd0);

        // Asynchronous reset in the high phase: outputs clear without an edge.
        push_period(4);
        step(1);
        RST_N = 1'b0;
        #1;
        check("async_rst_clk", 8'(CLK), 8'd0);
        check("async_rst_running", 8'(RUNNING), 8'd0);
        check("async_rst_div", DIV_ACTIVE, 8'd2);
`ifdef CLOCK_GEN_TICK_EN
        check("async_rst_tick", 8'(TICK), 8'd0);
`endif
        sb.delete();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
